// File: rtl/rack_spike_rx_if.sv
// rack_spike_rx_if: window clock, spike lines, host select and latched count outputs of the spike receiver.
interface rack_spike_rx_if #(
   parameter int NCH = 14,
   parameter int CW  = 16
);
   logic              sim_clk;
   logic [NCH-1:0]    spike_in;
   logic [3:0]        chan_sel;
   logic [NCH*CW-1:0] count_bus;
   logic [CW-1:0]     count_sel;
   logic [CW+3:0]     total_out;
   logic              window_valid;
   logic [NCH-1:0]    ovf;
   modport slave (input sim_clk, spike_in, chan_sel,
                  output count_bus, count_sel, total_out, window_valid, ovf);
   modport master (output sim_clk, spike_in, chan_sel,
                   input count_bus, count_sel, total_out, window_valid, ovf);
endinterface

// File: rtl/rack_spike_rx.sv
// rack_spike_rx: spike link receiver; syncs lines, counts rising edges per sim_clk window, latches counts.
// Define RACK_RX_GLITCH_EN to require MIN_HIGH synced high cycles before a line counts as high.
module rack_spike_rx #(
   parameter int NCH      = 14,
   parameter int CW       = 16,
   parameter int MIN_HIGH = 2
) (
   input logic            clk,
   input logic            reset_global,
   rack_spike_rx_if.slave bus
);
   logic [NCH-1:0] r_s1, r_s2, r_prev, r_live_ovf, r_ovf;
   logic           r_sim1, r_sim2, r_sim_prev;
   logic [CW-1:0]  r_cnt [NCH];
   logic [CW-1:0]  r_bus [NCH];
   logic [CW+3:0]  r_total;
   logic [CW-1:0]  r_sel;
   logic           r_valid;
   logic           w_tick;
   logic [NCH-1:0] w_level, w_rise;
   logic [CW+3:0]  w_sum;

   if (MIN_HIGH < 1) begin : g_chk
      $error("MIN_HIGH must be at least 1");
   end

`ifdef RACK_RX_GLITCH_EN
   localparam int HW = $clog2(MIN_HIGH) + 1;
   localparam logic [HW-1:0] HMAX = HW'(MIN_HIGH - 1);
   logic [HW-1:0] r_hcnt [NCH];
   // r_hcnt counts synced high cycles already seen; the level passes once MIN_HIGH-1 precede the current one
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global)
         for (int i = 0; i < NCH; i++) r_hcnt[i] <= '0;
      else
         for (int i = 0; i < NCH; i++)
            r_hcnt[i] <= !r_s2[i] ? '0 : (r_hcnt[i] == HMAX ? HMAX : r_hcnt[i] + 1'b1);
   end
   always_comb begin
      w_level = '0;
      for (int i = 0; i < NCH; i++) w_level[i] = r_s2[i] && r_hcnt[i] == HMAX;
   end
`else
   assign w_level = r_s2;
`endif

   assign w_rise = w_level & ~r_prev;
   assign w_tick = r_sim2 & ~r_sim_prev;

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NCH; i++) w_sum = w_sum + (CW+4)'(r_cnt[i]);
   end

   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_prev     <= '0;
         r_live_ovf <= '0;
         r_ovf      <= '0;
         r_sim1     <= 1'b0;
         r_sim2     <= 1'b0;
         r_sim_prev <= 1'b0;
         r_total    <= '0;
         r_sel      <= '0;
         r_valid    <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
            r_bus[i] <= '0;
         end
      end else begin
         r_s1       <= bus.spike_in;
         r_s2       <= r_s1;
         r_prev     <= w_level;
         r_sim1     <= bus.sim_clk;
         r_sim2     <= r_sim1;
         r_sim_prev <= r_sim2;
         r_valid    <= w_tick;
         r_sel      <= (32'(bus.chan_sel) < NCH) ? r_bus[bus.chan_sel] : '0;
         if (w_tick) begin
            // edges coincident with the tick open the new window
            r_ovf      <= r_live_ovf;
            r_live_ovf <= '0;
            r_total    <= w_sum;
            for (int i = 0; i < NCH; i++) begin
               r_bus[i] <= r_cnt[i];
               r_cnt[i] <= w_rise[i] ? CW'(1) : '0;
            end
         end else begin
            for (int i = 0; i < NCH; i++)
               if (w_rise[i]) begin
                  if (r_cnt[i] == '1) r_live_ovf[i] <= 1'b1;
                  else r_cnt[i] <= r_cnt[i] + 1'b1;
               end
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_bus
      assign bus.count_bus[g*CW +: CW] = r_bus[g];
   end
   assign bus.count_sel    = r_sel;
   assign bus.total_out    = r_total;
   assign bus.window_valid = r_valid;
   assign bus.ovf          = r_ovf;
endmodule

// File: tb/tb_rack_spike_rx.sv
// tb_rack_spike_rx: directed and randomized windows checked against per-window edge tallies kept by the bench.
module tb_rack_spike_rx;
   localparam int NCH = 14;
   localparam int CW  = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset_global = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   exp_n [NCH];

   rack_spike_rx_if #(.NCH(NCH), .CW(CW)) bus ();

   rack_spike_rx #(.NCH(NCH), .CW(CW), .MIN_HIGH(2)) dut (
      .clk(clk),
      .reset_global(reset_global),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NCH; i++) exp_n[i] = 0;
   endtask

   task automatic pulses(logic [NCH-1:0] mask, int n, int hi, int lo);
      repeat (n) begin
         bus.spike_in = mask;
         repeat (hi) @(negedge clk);
         bus.spike_in = '0;
         repeat (lo) @(negedge clk);
      end
      for (int i = 0; i < NCH; i++) if (mask[i]) exp_n[i] += n;
   endtask

   task automatic close_window(string tag);
      int t;
      int tot;
      int e;
      int sel;
      logic [NCH-1:0] eovf;
      bus.sim_clk = 1'b1;
      t = 0;
      while (bus.window_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " valid"}, bus.window_valid, 1);
      tot  = 0;
      eovf = '0;
      for (int i = 0; i < NCH; i++) begin
         e = exp_n[i] > MAXC ? MAXC : exp_n[i];
         tot += e;
         eovf[i] = exp_n[i] > MAXC;
         chk($sformatf("%s count[%0d]", tag, i), bus.count_bus[i*CW +: CW], e);
      end
      chk({tag, " total"}, bus.total_out, tot);
      chk({tag, " ovf"}, bus.ovf, eovf);
      @(negedge clk);
      chk({tag, " valid pulse"}, bus.window_valid, 0);
      sel = $urandom_range(0, 15);
      bus.chan_sel = 4'(sel);
      @(negedge clk);
      @(negedge clk);
      e = sel < NCH ? (exp_n[sel] > MAXC ? MAXC : exp_n[sel]) : 0;
      chk($sformatf("%s count_sel[%0d]", tag, sel), bus.count_sel, e);
      bus.sim_clk = 1'b0;
      repeat (4) @(negedge clk);
      clear_model();
   endtask

   initial begin
      int n [NCH];
      int seen;
      logic [NCH-1:0] m;
      clear_model();
      bus.sim_clk  = 1'b0;
      bus.spike_in = '0;
      bus.chan_sel = '0;
      // 1: reset holds everything at zero even with activity on the lines
      repeat (6) begin
         @(negedge clk);
         bus.spike_in = NCH'($urandom);
      end
      bus.spike_in = '0;
      @(negedge clk);
      chk("rst count_bus", bus.count_bus, 0);
      chk("rst total", bus.total_out, 0);
      chk("rst valid", bus.window_valid, 0);
      chk("rst ovf", bus.ovf, 0);
      chk("rst count_sel", bus.count_sel, 0);
      reset_global = 1'b0;
      repeat (3) @(negedge clk);
      close_window("t1");

      // 2: 5 on ch0, 3 on ch13
      pulses(NCH'(1) | (NCH'(1) << 13), 3, 4, 4);
      pulses(NCH'(1), 2, 4, 4);
      bus.chan_sel = 4'd13;
      close_window("t2");

      // 3: edge coincident with tick goes to the next window
      pulses(NCH'(1) << 5, 2, 4, 4);
      bus.spike_in = NCH'(1) << 5;
      close_window("t3a");
      exp_n[5] = 1;
      bus.spike_in = '0;
      repeat (4) @(negedge clk);
      close_window("t3b");

      // 4: saturation on ch2
      pulses(NCH'(1) << 2, 20, 2, 2);
      close_window("t4a");
      pulses(NCH'(1) << 2, 1, 4, 4);
      close_window("t4b");

      // 5: reset mid-window discards the partial window
      pulses(NCH'(1) << 1, 7, 3, 3);
      reset_global = 1'b1;
      @(negedge clk);
      reset_global = 1'b0;
      chk("t5 count_bus cleared", bus.count_bus, 0);
      chk("t5 total cleared", bus.total_out, 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.window_valid !== 1'b0) seen++;
      end
      chk("t5 no valid", seen, 0);
      clear_model();
      pulses(NCH'(1) << 1, 2, 4, 4);
      close_window("t5");

      // 6: narrow versus wide pulse
      bus.spike_in = NCH'(1) << 3;
      @(negedge clk);
      bus.spike_in = '0;
      repeat (4) @(negedge clk);
      bus.spike_in = NCH'(1) << 4;
      repeat (3) @(negedge clk);
      bus.spike_in = '0;
      repeat (4) @(negedge clk);
`ifdef RACK_RX_GLITCH_EN
      exp_n[3] = 0;
`else
      exp_n[3] = 1;
`endif
      exp_n[4] = 1;
      close_window("t6");

      // random windows
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < NCH; i++) n[i] = $urandom_range(0, 12);
         for (int k = 0; k < 12; k++) begin
            m = '0;
            for (int i = 0; i < NCH; i++) m[i] = n[i] > k;
            if (m != '0) pulses(m, 1, $urandom_range(2, 4), $urandom_range(2, 4));
         end
         close_window($sformatf("rnd%0d", w));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
